md_unit_ctrl: RTL

//  Sequencing controller for the E-stage multiply/divide resource (HI/LO) of the 5-stage MIPS pipeline.

---
 rtl/md_unit_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/md_unit_ctrl.sv
// ---------------------------------------------------------------------------
// md_unit_ctrl
// Sequencing controller for the E-stage multiply/divide resource of the
// 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E,
// models a fixed multi-cycle latency, owns the HI/LO registers and raises
// md_stall so that D-stage HI/LO users wait while an operation is in flight.
//
// Ports:
//   clk       in   1   clock, all state changes on posedge
//   reset     in   1   synchronous, active-low
//   E_MD_op   in   3   0/7 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
//   E_A       in  32   rs operand (forwarded)
//   E_B       in  32   rt operand (forwarded)
//   D_MD_use  in   1   D-stage instruction touches HI/LO or the md unit
//   cancel    in   1   E-stage flush (only with MD_CANCEL_EN defined)
//   busy      out  1   operation in flight (registered)
//   md_stall  out  1   D_MD_use & (busy | E_start) (combinational)
//   HI        out 32   HI register
//   LO        out 32   LO register
//
// Build option: define MD_CANCEL_EN to add the cancel input. Without it,
// every started operation commits.
// ---------------------------------------------------------------------------
module md_unit_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_MD_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_MD_use,
`ifdef MD_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_busy, w_busy_nxt;
    logic [31:0]       r_hi, w_hi_nxt;
    logic [31:0]       r_lo, w_lo_nxt;
    logic [31:0]       r_pend_hi, w_pend_hi_nxt;
    logic [31:0]       r_pend_lo, w_pend_lo_nxt;
    logic              r_pend_we, w_pend_we_nxt;

    logic              w_start;
    logic              w_cancel;

`ifdef MD_CANCEL_EN
    assign w_cancel = cancel;
`else
    assign w_cancel = 1'b0;
`endif

    assign w_start = (E_MD_op >= OP_MULT) && (E_MD_op <= OP_DIVU);

    // Arithmetic results of the E-stage operands; only latched on a start.
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic signed [31:0] w_a_s;
    logic signed [31:0] w_b_s;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic        [31:0] w_b_u;
    logic        [31:0] w_quo_u;
    logic        [31:0] w_rem_u;
    logic               w_b_zero;

    assign w_prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    assign w_prod_u = {32'd0, E_A} * {32'd0, E_B};
    assign w_b_zero = (E_B == 32'd0);

    // Divisor forced to 1 on B==0 so the dividers never see zero; the
    // result is dropped anyway because the commit is suppressed.
    assign w_a_s   = $signed(E_A);
    assign w_b_s   = w_b_zero ? 32'sd1 : $signed(E_B);
    assign w_quo_s = w_a_s / w_b_s;
    assign w_rem_s = w_a_s % w_b_s;
    assign w_b_u   = w_b_zero ? 32'd1 : E_B;
    assign w_quo_u = E_A / w_b_u;
    assign w_rem_u = E_A % w_b_u;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_we <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_we <= w_pend_we_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_busy_nxt    = r_busy;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_we_nxt = r_pend_we;

        case (r_state)
            S_IDLE: begin
                if (w_cancel) begin
                    // Flushed instruction: discard whatever op E presents.
                end else if (w_start) begin
                    w_state_nxt   = S_BUSY;
                    w_busy_nxt    = 1'b1;
                    w_pend_we_nxt = 1'b1;
                    case (E_MD_op)
                        OP_MULT: begin
                            w_pend_hi_nxt = w_prod_s[63:32];
                            w_pend_lo_nxt = w_prod_s[31:0];
                            w_cnt_nxt     = MULT_CNT;
                        end
                        OP_MULTU: begin
                            w_pend_hi_nxt = w_prod_u[63:32];
                            w_pend_lo_nxt = w_prod_u[31:0];
                            w_cnt_nxt     = MULT_CNT;
                        end
                        OP_DIV: begin
                            w_pend_hi_nxt = w_rem_s;
                            w_pend_lo_nxt = w_quo_s;
                            w_pend_we_nxt = !w_b_zero;
                            w_cnt_nxt     = DIV_CNT;
                        end
                        default: begin
                            w_pend_hi_nxt = w_rem_u;
                            w_pend_lo_nxt = w_quo_u;
                            w_pend_we_nxt = !w_b_zero;
                            w_cnt_nxt     = DIV_CNT;
                        end
                    endcase
                end else if (E_MD_op == OP_MTHI) begin
                    w_hi_nxt = E_A;
                end else if (E_MD_op == OP_MTLO) begin
                    w_lo_nxt = E_A;
                end
            end
            default: begin
                // Ops presented while busy are ignored; the stall keeps
                // them from reaching E in normal operation.
                if (w_cancel) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    if (r_pend_we) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
        endcase
    end

    assign busy     = r_busy;
    assign md_stall = D_MD_use & (r_busy | w_start);
    assign HI       = r_hi;
    assign LO       = r_lo;

endmodule
